// File: rtl/instr_reorder_pkg.sv
// Shared types and hazard helpers for the instruction reorder buffer.
package instr_reorder_pkg;

    typedef enum logic [2:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    typedef struct packed {
        logic [31:0] pc;
        fu_t         fu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } scoreboard_entry_t;

    typedef struct packed {
        scoreboard_entry_t sbe;
        logic              is_ctrl_flow;
    } rob_entry_t;

    function automatic logic is_mem(fu_t fu);
        return (fu == LOAD) || (fu == STORE);
    endfunction

    // Only plain ALU-class work may overtake a stalled memory op.
    function automatic logic is_alu_class(rob_entry_t e);
        return !is_mem(e.sbe.fu) && (e.sbe.fu != CTRL_FLOW) && !e.is_ctrl_flow;
    endfunction

    // Register-name hazard between a younger candidate and an older entry.
    // Stores write no rd and loads have no rs2 operand, hence the exemptions.
    function automatic logic hazard(rob_entry_t cand, rob_entry_t older);
        logic raw, war, waw;
        raw = ((cand.sbe.rs1 == older.sbe.rd) || (cand.sbe.rs2 == older.sbe.rd))
              && (older.sbe.fu != STORE);
        war = (cand.sbe.rd == older.sbe.rs1)
              || ((cand.sbe.rd == older.sbe.rs2) && (older.sbe.fu != LOAD));
        waw = (cand.sbe.rd == older.sbe.rd) && (older.sbe.fu != STORE);
        return raw || war || waw;
    endfunction

endpackage

// File: rtl/instr_reorder_buf_if.sv
// Issue-side handshake bundle: upstream entry/ack and downstream entry/ack.
interface instr_reorder_buf_if;
    import instr_reorder_pkg::*;

    scoreboard_entry_t issue_entry_i;
    logic              issue_entry_valid_i;
    logic              is_ctrl_flow_i;
    logic              issue_instr_ack_o;
    scoreboard_entry_t issue_entry_o;
    logic              issue_entry_valid_o;
    logic              is_ctrl_flow_o;
    logic              issue_instr_ack_i;

    modport master (
        output issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
        input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
    );

    modport slave (
        input  issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i, issue_instr_ack_i,
        output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
    );
endinterface

// File: rtl/instr_reorder_sel.sv
// Picks the slot to present: the head, or the oldest hazard-free ALU-class
// entry when the head is a memory op stalled on the LSU.
module instr_reorder_sel
    import instr_reorder_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_BYPASS = 3,
    parameter int unsigned REORDER_EN = 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned BYP_W     = $clog2(MAX_BYPASS + 1)
) (
    input  rob_entry_t       slots_i [DEPTH],
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             lsu_ready_i,
    input  logic [BYP_W-1:0] bypass_cnt_i,
    output logic [IDX_W-1:0] sel_idx_o,
    output logic             sel_bypass_o
);

    logic bypass_ok;
    logic found;
    logic clear;

    // Scan younger slots in age order; the first qualifying one wins.
    always_comb begin
        sel_idx_o    = '0;
        sel_bypass_o = 1'b0;
        found        = 1'b0;
        clear        = 1'b1;
        bypass_ok    = (REORDER_EN != 0) && (cnt_i != '0) && is_mem(slots_i[0].sbe.fu)
                       && !lsu_ready_i && (bypass_cnt_i < BYP_W'(MAX_BYPASS));
        for (int k = 1; k < int'(DEPTH); k++) begin
            clear = 1'b1;
            for (int j = 0; j < k; j++) begin
                if (hazard(slots_i[k], slots_i[j])) clear = 1'b0;
            end
            if (bypass_ok && !found && (k < int'(cnt_i)) && is_alu_class(slots_i[k]) && clear) begin
                found        = 1'b1;
                sel_idx_o    = IDX_W'(k);
                sel_bypass_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_reorder_buf.sv
// Age-ordered reorder buffer between the issue FIFO and the issue stage.
// Empty buffer passes straight through; control flow is never stored.
module instr_reorder_buf
    import instr_reorder_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_BYPASS = 3,
    parameter int unsigned REORDER_EN = 1,
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1),
    localparam int unsigned IDX_W     = $clog2(DEPTH),
    localparam int unsigned BYP_W     = $clog2(MAX_BYPASS + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               flush_i,
    input  logic               lsu_ready_i,
    instr_reorder_buf_if.slave bus,
    output logic [CNT_W-1:0]   occupancy_o,
    output logic               bypass_o
);

    rob_entry_t       slots_q [DEPTH];
    rob_entry_t       slots_d [DEPTH];
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_after;
    logic [BYP_W-1:0] byp_cnt_q, byp_cnt_d;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_bypass;
    logic             empty, deq, enq, bypass_fire;
    rob_entry_t       head;

    instr_reorder_sel #(
        .DEPTH      (DEPTH),
        .MAX_BYPASS (MAX_BYPASS),
        .REORDER_EN (REORDER_EN)
    ) u_sel (
        .slots_i      (slots_q),
        .cnt_i        (cnt_q),
        .lsu_ready_i  (lsu_ready_i),
        .bypass_cnt_i (byp_cnt_q),
        .sel_idx_o    (sel_idx),
        .sel_bypass_o (sel_bypass)
    );

    // Output mux and input acceptance; flush overrides both handshakes.
    always_comb begin
        empty = (cnt_q == '0);
        head  = slots_q[sel_idx];
        if (empty) begin
            bus.issue_entry_o       = bus.issue_entry_i;
            bus.issue_entry_valid_o = bus.issue_entry_valid_i & ~flush_i;
            bus.is_ctrl_flow_o      = bus.is_ctrl_flow_i;
        end else begin
            bus.issue_entry_o       = head.sbe;
            bus.issue_entry_valid_o = ~flush_i;
            bus.is_ctrl_flow_o      = head.is_ctrl_flow;
        end

        if (flush_i) begin
            bus.issue_instr_ack_o = 1'b0;
        end else if (empty) begin
            bus.issue_instr_ack_o = bus.issue_instr_ack_i
                                    | (bus.issue_entry_valid_i & ~bus.is_ctrl_flow_i);
        end else if (bus.is_ctrl_flow_i) begin
            bus.issue_instr_ack_o = 1'b0;
        end else begin
            bus.issue_instr_ack_o = (cnt_q < CNT_W'(DEPTH)) | bus.issue_instr_ack_i;
        end

        deq         = ~empty & bus.issue_instr_ack_i & ~flush_i;
        enq         = bus.issue_entry_valid_i & bus.issue_instr_ack_o & ~bus.is_ctrl_flow_i
                      & ~(empty & bus.issue_instr_ack_i);
        bypass_fire = deq & sel_bypass;
    end

    // Next state: compact over the removed slot, then append at the new tail.
    always_comb begin
        slots_d   = slots_q;
        cnt_after = cnt_q - CNT_W'(deq);
        if (deq) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                if (i >= int'(sel_idx)) slots_d[i] = slots_q[i+1];
            end
        end
        if (enq) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (i == int'(cnt_after)) begin
                    slots_d[i] = '{sbe: bus.issue_entry_i, is_ctrl_flow: bus.is_ctrl_flow_i};
                end
            end
        end
        cnt_d = flush_i ? '0 : cnt_after + CNT_W'(enq);

        byp_cnt_d = byp_cnt_q;
        if (flush_i || (deq && !sel_bypass)) begin
            byp_cnt_d = '0;
        end else if (bypass_fire && (byp_cnt_q < BYP_W'(MAX_BYPASS))) begin
            byp_cnt_d = byp_cnt_q + 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) slots_q[i] <= '0;
            cnt_q     <= '0;
            byp_cnt_q <= '0;
        end else begin
            slots_q   <= slots_d;
            cnt_q     <= cnt_d;
            byp_cnt_q <= byp_cnt_d;
        end
    end

    assign occupancy_o = cnt_q;
    assign bypass_o    = bypass_fire;

endmodule

// File: tb/tb_instr_reorder_buf.sv
// Scoreboard bench: stimulus queues expected issue order, a negedge monitor
// pops and compares every accepted output.
module tb_instr_reorder_buf;
    import instr_reorder_pkg::*;

    typedef struct {
        logic [31:0] pc;
        logic        byp;
        logic        ctrl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       lsu_ready = 1'b1;
    logic [2:0] occupancy;
    logic       bypass;
    int         checks = 0;
    int         failures = 0;
    exp_t       exp_q[$];
    exp_t       e;

    instr_reorder_buf_if ifc ();

    instr_reorder_buf #(.DEPTH(4), .MAX_BYPASS(3), .REORDER_EN(1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .lsu_ready_i (lsu_ready),
        .bus         (ifc.slave),
        .occupancy_o (occupancy),
        .bypass_o    (bypass)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic scoreboard_entry_t mk(input logic [31:0] pc, input fu_t fu,
                                             input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2);
        scoreboard_entry_t s;
        s.pc = pc; s.fu = fu; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2;
        return s;
    endfunction

    task automatic drive(input logic v, input scoreboard_entry_t s, input logic ctrl,
                         input logic ack, input logic lsu);
        ifc.issue_entry_valid_i = v;
        ifc.issue_entry_i       = s;
        ifc.is_ctrl_flow_i      = ctrl;
        ifc.issue_instr_ack_i   = ack;
        lsu_ready               = lsu;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [31:0] pc, input logic byp, input logic ctrl);
        exp_t x;
        x.pc = pc; x.byp = byp; x.ctrl = ctrl;
        exp_q.push_back(x);
    endtask

    // Monitor: every accepted output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ifc.issue_entry_valid_o && ifc.issue_instr_ack_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual_pc=%0h required=none", ifc.issue_entry_o.pc);
            end else begin
                e = exp_q.pop_front();
                check("out_pc", ifc.issue_entry_o.pc, e.pc);
                check("out_bypass", {31'b0, bypass}, {31'b0, e.byp});
                check("out_ctrl", {31'b0, ifc.is_ctrl_flow_o}, {31'b0, e.ctrl});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        #12;
        rst_n = 1'b1;
        tick();
        check("rst_occ", {29'b0, occupancy}, 0);
        check("rst_bypass", {31'b0, bypass}, 0);
        check("rst_valid_o", {31'b0, ifc.issue_entry_valid_o}, 0);

        // Empty-buffer passthrough
        drive(1'b1, mk(32'h100, ALU, 5'd3, 5'd1, 5'd2), 1'b0, 1'b1, 1'b1);
        expect_out(32'h100, 1'b0, 1'b0);
        #1;
        check("pt_ack_o", {31'b0, ifc.issue_instr_ack_o}, 1);
        check("pt_valid_o", {31'b0, ifc.issue_entry_valid_o}, 1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        check("pt_occ", {29'b0, occupancy}, 0);

        // Two ADDs bypass a stalled LOAD
        drive(1'b1, mk(32'h200, LOAD, 5'd5, 5'd10, 5'd0), 1'b0, 1'b0, 1'b1);
        #1;
        check("fill_ack_o", {31'b0, ifc.issue_instr_ack_o}, 1);
        tick();
        drive(1'b1, mk(32'h201, ALU, 5'd6, 5'd1, 5'd11), 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b1, mk(32'h202, ALU, 5'd7, 5'd2, 5'd12), 1'b0, 1'b0, 1'b1);
        tick();
        check("s2_occ", {29'b0, occupancy}, 3);
        expect_out(32'h201, 1'b1, 1'b0);
        expect_out(32'h202, 1'b1, 1'b0);
        expect_out(32'h200, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check("s2_occ_end", {29'b0, occupancy}, 0);

        // RAW-dependent ADD must not overtake its LOAD
        drive(1'b1, mk(32'h300, LOAD, 5'd5, 5'd10, 5'd0), 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, mk(32'h301, ALU, 5'd6, 5'd5, 5'd11), 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("raw_head", ifc.issue_entry_o.pc, 32'h300);
        tick();
        check("raw_head2", ifc.issue_entry_o.pc, 32'h300);
        expect_out(32'h300, 1'b0, 1'b0);
        expect_out(32'h301, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
        repeat (2) tick();
        check("raw_occ_end", {29'b0, occupancy}, 0);

        // Starvation bound: three bypasses, then the STORE holds the output
        drive(1'b1, mk(32'h400, STORE, 5'd0, 5'd20, 5'd21), 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(32'h400 + i, ALU, 5'(i), 5'd26, 5'd27), 1'b0, 1'b0, 1'b0);
            tick();
        end
        check("sb_full", {29'b0, occupancy}, 4);
        expect_out(32'h401, 1'b1, 1'b0);
        expect_out(32'h402, 1'b1, 1'b0);
        expect_out(32'h403, 1'b1, 1'b0);
        expect_out(32'h400, 1'b0, 1'b0);
        expect_out(32'h404, 1'b0, 1'b0);
        expect_out(32'h405, 1'b0, 1'b0);
        drive(1'b1, mk(32'h404, ALU, 5'd4, 5'd26, 5'd27), 1'b0, 1'b1, 1'b0);
        #1;
        check("full_ack_o", {31'b0, ifc.issue_instr_ack_o}, 1);
        tick();
        check("full_occ", {29'b0, occupancy}, 4);
        drive(1'b1, mk(32'h405, ALU, 5'd5, 5'd26, 5'd27), 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("sb_hold", ifc.issue_entry_o.pc, 32'h400);
        tick();
        check("sb_hold2", ifc.issue_entry_o.pc, 32'h400);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (3) tick();
        check("sb_occ_end", {29'b0, occupancy}, 0);

        // Control flow waits for a full buffer to drain
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, mk(32'h500 + i, ALU, 5'(i), 5'd26, 5'd27), 1'b0, 1'b0, 1'b1);
            expect_out(32'h500 + i, 1'b0, 1'b0);
            tick();
        end
        expect_out(32'h510, 1'b0, 1'b1);
        drive(1'b1, mk(32'h510, CTRL_FLOW, 5'd0, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1);
        #1;
        check("cf_full_ack", {31'b0, ifc.issue_instr_ack_o}, 0);
        check("cf_full_occ", {29'b0, occupancy}, 4);
        tick();
        ifc.issue_instr_ack_i = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            #1;
            check("cf_ack_o", {31'b0, ifc.issue_instr_ack_o}, (i == 4) ? 1 : 0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        #1;
        check("cf_occ_end", {29'b0, occupancy}, 0);

        // Flush drops contents and the bypass count
        drive(1'b1, mk(32'h600, LOAD, 5'd5, 5'd10, 5'd0), 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 2; i++) begin
            drive(1'b1, mk(32'h600 + i, ALU, 5'(i), 5'd26, 5'd27), 1'b0, 1'b0, 1'b0);
            tick();
        end
        expect_out(32'h601, 1'b1, 1'b0);
        drive(1'b1, mk(32'h603, ALU, 5'd3, 5'd26, 5'd27), 1'b0, 1'b1, 1'b0);
        tick();
        check("fl_pre_occ", {29'b0, occupancy}, 3);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_valid_o", {31'b0, ifc.issue_entry_valid_o}, 0);
        check("fl_ack_o", {31'b0, ifc.issue_instr_ack_o}, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check("fl_occ", {29'b0, occupancy}, 0);
        drive(1'b1, mk(32'h610, LOAD, 5'd5, 5'd10, 5'd0), 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, mk(32'h610 + i, ALU, 5'(i), 5'd26, 5'd27), 1'b0, 1'b0, 1'b0);
            expect_out(32'h610 + i, 1'b1, 1'b0);
            tick();
        end
        expect_out(32'h610, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        repeat (4) tick();
        check("fl_occ_end", {29'b0, occupancy}, 0);

        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_reorder_buf.md
Name: instr_reorder_buf

Overview:
- Parametrised DEPTH-entry reorder buffer between the issue FIFO output and the scoreboard/issue stage, replacing the single-slot delay register.
- When the oldest entry is a LOAD/STORE and the LSU is not ready, the buffer issues the oldest younger hazard-free ALU-class instruction ahead of it.
- A starvation bound (MAX_BYPASS) and a global disable mode are added; control-flow instructions never enter the buffer.

Parameters:
- DEPTH, 4, number of buffered entries (≥2).
- MAX_BYPASS, 3, max instructions issued ahead of the same head memory op before bypass is inhibited (≥1).
- REORDER_EN, 1, 0 = in-order elastic buffer only (no bypass logic).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- flush_i  in  1  pipeline flush
- issue_entry_i  in  scoreboard_entry_t  incoming decoded instruction
- issue_entry_valid_i  in  1  input valid
- is_ctrl_flow_i  in  1  input is control flow
- issue_instr_ack_o  out  1  input accepted this cycle
- issue_entry_o  out  scoreboard_entry_t  instruction presented to issue
- issue_entry_valid_o  out  1  output valid
- is_ctrl_flow_o  out  1  output is control flow
- issue_instr_ack_i  in  1  issue stage accepted output
- lsu_ready_i  in  1  LSU can take a memory op
- occupancy_o  out  $clog2(DEPTH+1)  buffered entry count
- bypass_o  out  1  pulse: output taken from a non-head slot

Behaviour:
- Reset is clk_i / rst_ni, asynchronous, active-low.
  - Reset state: buffer empty, bypass counter 0, occupancy_o=0, bypass_o=0.
  - Outputs then follow the empty-buffer passthrough below.
- Storage: age-ordered queue, slot 0 = oldest. At most 1 output and 1 input per cycle. Removal from any slot compacts younger slots down by one in the same edge; the enqueue lands at the post-compaction tail.
- Empty buffer (passthrough, 0 latency):
  - issue_entry_o/valid_o/is_ctrl_flow_o = inputs.
  - If issue_instr_ack_i: issue_instr_ack_o=1 and nothing is stored.
  - Else a non-ctrl-flow valid input is stored in slot 0 with ack_o=1; a ctrl-flow input gets ack_o=0.
- Non-empty, output selection:
  - Default: slot 0.
  - Bypass is taken when REORDER_EN=1, slot 0 fu∈{LOAD,STORE}, !lsu_ready_i, and bypass_cnt<MAX_BYPASS. The output is the lowest-index slot k≥1 satisfying all of:
    - fu∉{LOAD,STORE,CTRL_FLOW} and !is_ctrl_flow;
    - hazard-free against every slot j<k.
  - No qualifying slot → slot 0.
  - The incoming instruction is never a bypass candidate in the same cycle.
- Hazard between candidate C and older O (full-field compares, no x0 exemption):
  - RAW: C.rs1==O.rd or C.rs2==O.rd, unless O.fu==STORE.
  - WAR: C.rd==O.rs1; C.rd==O.rs2 unless O.fu==LOAD.
  - WAW: C.rd==O.rd unless O.fu==STORE.
- Acceptance when non-empty:
  - ctrl-flow input: ack_o=0; it waits until the buffer drains.
  - Other inputs: ack_o = (occupancy<DEPTH) | issue_instr_ack_i.
- bypass_cnt:
  - +1 on each accepted bypass output.
  - Cleared when slot 0 leaves or on flush.
  - Saturates at MAX_BYPASS.
- bypass_o=1 exactly in cycles where a bypass output is acked.
- flush_i (highest priority):
  - Same cycle: issue_entry_valid_o=0, issue_instr_ack_o=0.
  - Next edge: buffer emptied, bypass_cnt=0.
- Full + issue_instr_ack_i in the same cycle: dequeue and enqueue both happen; occupancy unchanged.
- Invalid input (valid_i=0) is never enqueued.

Decomposition:
- instr_reorder_pkg:
  - rob_entry_t {scoreboard_entry_t sbe; logic is_ctrl_flow}
  - function is_mem(fu)
  - function hazard(cand, older)
- Sub-module instr_reorder_sel:
  - Combinational candidate scan; outputs sel_idx and sel_bypass.
  - Instantiated once.

Test Plan:
- Empty buffer, ack_i=1, ADD valid → output=ADD the same cycle, occupancy stays 0, no storage.
- ack_i=0 for 3 cycles while LOAD x5, ADD x6←x1, ADD x7←x2 arrive; then lsu_ready_i=0, ack_i=1 → ADD x6 issued first with bypass_o=1, then ADD x7, then LOAD.
- LOAD x5 at head, lsu_ready_i=0, younger ADD x6←x5 → no bypass (RAW); LOAD issued once lsu_ready_i=1.
- MAX_BYPASS=3, head STORE, 5 independent ADDs, lsu_ready_i=0 → exactly 3 ADDs bypass, then output stays STORE until it is acked.
- Buffer full (4), BEQ at input → ack_o=0 until occupancy=0 and ack_i=1, then BEQ passes through.
- Buffer holding 3 entries, flush_i=1 → valid_o=0 that cycle, occupancy_o=0 the next cycle, bypass_cnt=0.
